// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master drives operands and commands. The multiplier is the slave.
interface booth_multiplier_if;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplier;
    logic [31:0] multiplicand;
    logic        op_done;
    logic [63:0] result;

    modport master (
        output op_start, op_clear, multiplier, multiplicand,
        input  op_done, result
    );
    modport slave (
        input  op_start, op_clear, multiplier, multiplicand,
        output op_done, result
    );
endinterface

// File: rtl/booth_multiplier.sv
// Signed 32x32->64 radix-2 Booth multiplier: one Booth step per clock, 32 steps.
// The product {U,V} is held in DONE until op_clear.
module booth_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

module booth_multiplier (
    input  logic              clk,
    input  logic              reset,
    booth_multiplier_if.slave bus
);
    typedef enum logic [1:0] {
        INIT = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    logic [1:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] x_q, x_d, m_q, m_d, u_q, u_d, v_q, v_d;
    logic        xp_q, xp_d;
    logic [32:0] sum;

    booth_reg #(.W(2))  u_state (.clk(clk), .reset(reset), .d(state_d), .q(state_q));
    booth_reg #(.W(6))  u_count (.clk(clk), .reset(reset), .d(count_d), .q(count_q));
    booth_reg #(.W(32)) u_x     (.clk(clk), .reset(reset), .d(x_d),     .q(x_q));
    booth_reg #(.W(32)) u_m     (.clk(clk), .reset(reset), .d(m_d),     .q(m_q));
    booth_reg #(.W(32)) u_u     (.clk(clk), .reset(reset), .d(u_d),     .q(u_q));
    booth_reg #(.W(32)) u_v     (.clk(clk), .reset(reset), .d(v_d),     .q(v_q));
    booth_reg #(.W(1))  u_xp    (.clk(clk), .reset(reset), .d(xp_d),    .q(xp_q));

    // 33-bit add/sub keeps M = -2^31 exact
    always_comb begin
        case ({x_q[0], xp_q})
            2'b10:   sum = {u_q[31], u_q} - {m_q[31], m_q};
            2'b01:   sum = {u_q[31], u_q} + {m_q[31], m_q};
            default: sum = {u_q[31], u_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        m_d     = m_q;
        u_d     = u_q;
        v_d     = v_q;
        xp_d    = xp_q;
        if (bus.op_clear) begin
            state_d = INIT;
            count_d = '0;
            x_d     = '0;
            m_d     = '0;
            u_d     = '0;
            v_d     = '0;
            xp_d    = 1'b0;
        end else begin
            case (state_t'(state_q))
                INIT: if (bus.op_start) begin
                    state_d = EXEC;
                    x_d     = bus.multiplier;
                    m_d     = bus.multiplicand;
                    u_d     = '0;
                    v_d     = '0;
                    xp_d    = 1'b0;
                    count_d = '0;
                end
                EXEC: begin
                    u_d     = sum[32:1];
                    v_d     = {sum[0], v_q[31:1]};
                    xp_d    = x_q[0];
                    x_d     = x_q >> 1;
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd31) state_d = DONE;
                end
                DONE: ;
                // encoding 11 recovers to INIT
                default: state_d = INIT;
            endcase
        end
    end

    assign bus.op_done = (state_t'(state_q) == DONE);
    assign bus.result  = {u_q, v_q};
endmodule
